// File: rtl/ysyx_24100005_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100005_lsu
//  Purpose  : Multi-cycle load/store unit between the NPC execute stage and
//             the data-memory bus. Handles byte-lane placement, write-mask
//             generation, load extraction with sign/zero extension and a
//             bus response timeout.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W       datapath width, 32 or 64
//    ADDR_W       byte address width
//    TIMEOUT_CYC  max cycles waiting for a bus response (0 = no timeout)
//  Build option
//    LSU_MISALIGN_TRAP_EN  when defined, misaligned accesses are rejected
//                          with rsp_err and never reach the bus
//  Ports
//    clk, rst                       clock / async active-high reset
//    req_valid/ready/wen/funct3/addr/wdata   core request channel
//    rsp_valid/ready/rdata/err              core response channel
//    mem_req_valid/ready/wen/addr/wdata/wmask  bus request channel
//    mem_rsp_valid/rdata                    bus response channel
// ============================================================================
module ysyx_24100005_lsu #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata
);

    localparam int c_NB         = DATA_W / 8;
    localparam int c_OFF_W      = $clog2(c_NB);
    localparam int c_SH_W       = c_OFF_W + 3;
    localparam bit c_IS64       = (DATA_W == 64);
    localparam bit c_TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam int c_TO_LAST    = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam int c_CNT_W      = (c_TO_LAST < 2) ? 1 : $clog2(c_TO_LAST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_wen;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_f3_legal;
    logic                w_legal;
    logic                w_timeout;
    logic [c_OFF_W-1:0]  w_off;
    logic [c_SH_W-1:0]   w_shamt;
    logic [c_NB-1:0]     w_base_mask;
    logic [DATA_W-1:0]   w_ld_sh;
    logic [DATA_W-1:0]   w_ld_ext;

    // ------------------------------------------------------------------
    // Request legality, evaluated on the incoming request so the decision
    // is taken on the same edge that captures it.
    // ------------------------------------------------------------------
    always_comb begin
        w_f3_legal = 1'b0;
        if (req_wen) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
                3'b011:                 w_f3_legal = c_IS64;
                default:                w_f3_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101:         w_f3_legal = 1'b1;
                3'b011, 3'b110:         w_f3_legal = c_IS64;
                default:                w_f3_legal = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] encodes log2 of the access size for every legal code
    // (lbu/lhu/lwu share the size bits of lb/lh/lw).
    logic [2:0] w_size_mask;
    logic [2:0] w_req_off;
    logic       w_misaligned;

    always_comb begin
        w_size_mask = 3'b000;
        case (req_funct3[1:0])
            2'd0:    w_size_mask = 3'b000;
            2'd1:    w_size_mask = 3'b001;
            2'd2:    w_size_mask = 3'b011;
            default: w_size_mask = 3'b111;
        endcase
    end

    assign w_req_off    = 3'(req_addr[c_OFF_W-1:0]);
    assign w_misaligned = |(w_req_off & w_size_mask);
    assign w_legal      = w_f3_legal & ~w_misaligned;
`else
    assign w_legal      = w_f3_legal;
`endif

    // ------------------------------------------------------------------
    // Byte-lane placement for stores; shifts discard lanes beyond NB.
    // ------------------------------------------------------------------
    assign w_off   = r_addr[c_OFF_W-1:0];
    assign w_shamt = {w_off, 3'b000};

    always_comb begin
        w_base_mask = '0;
        case (r_funct3[1:0])
            2'd0:    w_base_mask = c_NB'(8'h01);
            2'd1:    w_base_mask = c_NB'(8'h03);
            2'd2:    w_base_mask = c_NB'(8'h0F);
            default: w_base_mask = c_NB'(8'hFF);
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction: bring the addressed lane down to bit 0, then extend.
    // ------------------------------------------------------------------
    assign w_ld_sh = mem_rsp_rdata >> w_shamt;

    generate
        if (c_IS64) begin : g_ext64
            always_comb begin
                w_ld_ext = '0;
                case (r_funct3)
                    3'b000:  w_ld_ext = {{56{w_ld_sh[7]}},  w_ld_sh[7:0]};
                    3'b001:  w_ld_ext = {{48{w_ld_sh[15]}}, w_ld_sh[15:0]};
                    3'b010:  w_ld_ext = {{32{w_ld_sh[31]}}, w_ld_sh[31:0]};
                    3'b011:  w_ld_ext = w_ld_sh;
                    3'b100:  w_ld_ext = {56'd0, w_ld_sh[7:0]};
                    3'b101:  w_ld_ext = {48'd0, w_ld_sh[15:0]};
                    3'b110:  w_ld_ext = {32'd0, w_ld_sh[31:0]};
                    default: w_ld_ext = '0;
                endcase
            end
        end else begin : g_ext32
            always_comb begin
                w_ld_ext = '0;
                case (r_funct3)
                    3'b000:  w_ld_ext = {{24{w_ld_sh[7]}},  w_ld_sh[7:0]};
                    3'b001:  w_ld_ext = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
                    3'b010:  w_ld_ext = w_ld_sh;
                    3'b100:  w_ld_ext = {24'd0, w_ld_sh[7:0]};
                    3'b101:  w_ld_ext = {16'd0, w_ld_sh[15:0]};
                    default: w_ld_ext = '0;
                endcase
            end
        end
    endgenerate

    assign w_timeout = c_TIMEOUT_EN && (r_cnt == c_CNT_W'(c_TO_LAST));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving on the timeout cycle still wins,
                // both lead to RESP and the datapath picks the response.
                if (mem_rsp_valid || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, timeout counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen    <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen    <= req_wen;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= '0;
                        r_err    <= ~w_legal;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_rdata <= r_wen ? '0 : w_ld_ext;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else if (c_TIMEOUT_EN) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus fields only carry the request while in ISSUE and the
    // response fields only while in RESP, so idle outputs read as zero.
    // ------------------------------------------------------------------
    assign req_ready     = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_ISSUE);
    assign mem_req_wen   = mem_req_valid & r_wen;
    assign mem_req_addr  = mem_req_valid ? {r_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}} : '0;
    assign mem_req_wdata = (mem_req_valid && r_wen) ? (r_wdata << w_shamt) : '0;
    assign mem_req_wmask = (mem_req_valid && r_wen) ? (w_base_mask << w_off) : '0;
    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_rdata     = rsp_valid ? r_rdata : '0;
    assign rsp_err       = rsp_valid & r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24100005_lsu
//  Purpose  : Directed self-checking bench for the load/store unit. Instance
//             A is RV32 with an 8-cycle timeout, instance B is RV64 with the
//             default timeout. Both share clk and rst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: DATA_W = 32, TIMEOUT_CYC = 8 ----------
    logic        a_req_valid = 0, a_req_wen = 0, a_rsp_ready = 0;
    logic [2:0]  a_req_funct3 = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic        a_mem_req_ready = 0, a_mem_rsp_valid = 0;
    logic [31:0] a_mem_rsp_rdata = 0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        a_mem_req_valid, a_mem_req_wen;
    logic [31:0] a_mem_req_addr, a_mem_req_wdata;
    logic [3:0]  a_mem_req_wmask;

    ysyx_24100005_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(8)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
        .mem_req_wen(a_mem_req_wen), .mem_req_addr(a_mem_req_addr),
        .mem_req_wdata(a_mem_req_wdata), .mem_req_wmask(a_mem_req_wmask),
        .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_rdata(a_mem_rsp_rdata)
    );

    // ---------------- instance B: DATA_W = 64 ---------------------------
    logic        b_req_valid = 0, b_req_wen = 0, b_rsp_ready = 0;
    logic [2:0]  b_req_funct3 = 0;
    logic [31:0] b_req_addr = 0;
    logic [63:0] b_req_wdata = 0;
    logic        b_mem_req_ready = 0, b_mem_rsp_valid = 0;
    logic [63:0] b_mem_rsp_rdata = 0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [63:0] b_rsp_rdata;
    logic        b_mem_req_valid, b_mem_req_wen;
    logic [31:0] b_mem_req_addr;
    logic [63:0] b_mem_req_wdata;
    logic [7:0]  b_mem_req_wmask;

    ysyx_24100005_lsu #(.DATA_W(64), .ADDR_W(32)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
        .mem_req_wen(b_mem_req_wen), .mem_req_addr(b_mem_req_addr),
        .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_rdata(b_mem_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drain();
        a_rsp_ready = 1'b1;
        step();
        a_rsp_ready = 1'b0;
    endtask

    task automatic b_drain();
        b_rsp_ready = 1'b1;
        step();
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        chk("rst_a_req_ready", a_req_ready, 1);
        chk("rst_a_outs", {a_rsp_valid, a_rsp_err, a_mem_req_valid, a_mem_req_wen},  4'b0000);
        chk("rst_a_data", {a_rsp_rdata, a_mem_req_addr}, 64'd0);
        chk("rst_a_wdata_mask", {a_mem_req_wdata, a_mem_req_wmask}, 36'd0);
        chk("rst_b_req_ready", b_req_ready, 1);
        rst = 1'b0;
        step();

        // ---------------- lb @0x80000003, 3-cycle latency ----------------
        a_req_valid = 1; a_req_wen = 0; a_req_funct3 = 3'b000;
        a_req_addr = 32'h8000_0003; a_req_wdata = 32'h0;
        a_mem_req_ready = 1; a_mem_rsp_valid = 1; a_mem_rsp_rdata = 32'h80AA_BBCC;
        chk("lb_req_ready", a_req_ready, 1);
        step();                     // accepted -> ISSUE
        a_req_valid = 0;
        chk("lb_issue_valid", a_mem_req_valid, 1);
        chk("lb_issue_addr", a_mem_req_addr, 32'h8000_0000);
        chk("lb_issue_wmask_wen", {a_mem_req_wmask, a_mem_req_wen}, 5'b00000);
        chk("lb_c1_rsp_valid", a_rsp_valid, 0);
        step();                     // WAIT
        chk("lb_c2_rsp_valid", a_rsp_valid, 0);
        step();                     // RESP
        chk("lb_c3_rsp_valid", a_rsp_valid, 1);
        chk("lb_rdata", a_rsp_rdata, 32'hFFFF_FF80);
        chk("lb_err", a_rsp_err, 0);
        chk("lb_resp_req_ready", a_req_ready, 0);
        a_drain();
        chk("lb_back_idle", {a_req_ready, a_rsp_valid}, 2'b10);

        // ---------------- sh @0x80000002 ----------------
        a_req_valid = 1; a_req_wen = 1; a_req_funct3 = 3'b001;
        a_req_addr = 32'h8000_0002; a_req_wdata = 32'h0000_1234;
        step();
        a_req_valid = 0;
        chk("sh_wmask", a_mem_req_wmask, 4'b1100);
        chk("sh_wdata", a_mem_req_wdata, 32'h1234_0000);
        chk("sh_wen", a_mem_req_wen, 1);
        chk("sh_addr", a_mem_req_addr, 32'h8000_0000);
        step();
        step();
        chk("sh_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, {2'b10, 32'h0});
        a_drain();

        // ---------------- lhu @0x80000000 with 4 stall cycles ----------------
        a_req_valid = 1; a_req_wen = 0; a_req_funct3 = 3'b101;
        a_req_addr = 32'h8000_0000; a_req_wdata = 32'hFFFF_FFFF;
        a_mem_req_ready = 0; a_mem_rsp_rdata = 32'h0000_F00D;
        step();
        a_req_valid = 0;
        a_req_addr = 32'h1234_5678;     // request bus changes must not leak
        for (int i = 0; i < 4; i++) begin
            chk("lhu_stall_hold",
                {a_mem_req_valid, a_mem_req_wen, a_mem_req_addr, a_mem_req_wmask},
                {1'b1, 1'b0, 32'h8000_0000, 4'h0});
            if (i == 3) a_mem_req_ready = 1;
            step();
        end
        chk("lhu_wait_no_req", a_mem_req_valid, 0);
        step();
        chk("lhu_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, {2'b10, 32'h0000_F00D});
        a_drain();

        // ---------------- lw timeout after 8 WAIT cycles ----------------
        a_req_valid = 1; a_req_wen = 0; a_req_funct3 = 3'b010;
        a_req_addr = 32'h8000_0004; a_mem_rsp_valid = 0;
        step();
        a_req_valid = 0;
        step();                     // WAIT, counter 0
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_no_rsp", a_rsp_valid, 0);
            step();
        end
        chk("to_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, {2'b11, 32'h0});
        step();
        step();
        a_mem_rsp_valid = 1; a_mem_rsp_rdata = 32'h1234_5678;
        step();
        a_mem_rsp_valid = 0;
        chk("to_late_ignored", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, {2'b11, 32'h0});
        a_drain();
        a_mem_rsp_valid = 1;
        step();
        a_mem_rsp_valid = 0;
        chk("to_idle_ignored", {a_req_ready, a_rsp_valid, a_mem_req_valid}, 3'b100);

        // ---------------- illegal funct3 = 111 load ----------------
        a_mem_rsp_valid = 1;
        a_req_valid = 1; a_req_wen = 0; a_req_funct3 = 3'b111;
        a_req_addr = 32'h8000_0000;
        step();
        a_req_valid = 0;
        chk("ill_c1", {a_mem_req_valid, a_rsp_valid, a_rsp_err, a_rsp_rdata}, {3'b011, 32'h0});
        step();
        chk("ill_c2", {a_mem_req_valid, a_rsp_valid, a_rsp_err}, 3'b011);
        a_drain();

        // ---------------- misaligned lw @0x80000001 ----------------
        a_req_valid = 1; a_req_wen = 0; a_req_funct3 = 3'b010;
        a_req_addr = 32'h8000_0001; a_mem_rsp_rdata = 32'hDEAD_BEEF;
        step();
        a_req_valid = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_c1", {a_mem_req_valid, a_rsp_valid, a_rsp_err}, 3'b011);
        step();
        chk("mis_c2", {a_mem_req_valid, a_rsp_valid, a_rsp_err}, 3'b011);
        a_drain();
`else
        chk("mis_issue", {a_mem_req_valid, a_mem_req_addr}, {1'b1, 32'h8000_0000});
        step();
        step();
        chk("mis_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, {2'b10, 32'h00DE_ADBE});
        a_drain();
        // misaligned sw: upper lane truncated
        a_req_valid = 1; a_req_wen = 1; a_req_funct3 = 3'b010;
        a_req_addr = 32'h8000_0001; a_req_wdata = 32'hAABB_CCDD;
        step();
        a_req_valid = 0;
        chk("mis_sw_mask_data", {a_mem_req_wmask, a_mem_req_wdata}, {4'hE, 32'hBBCC_DD00});
        step();
        step();
        chk("mis_sw_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, {2'b10, 32'h0});
        a_drain();
`endif

        // ---------------- RV64: ld @0x80000008 ----------------
        b_req_valid = 1; b_req_wen = 0; b_req_funct3 = 3'b011;
        b_req_addr = 32'h8000_0008;
        b_mem_req_ready = 1; b_mem_rsp_valid = 1; b_mem_rsp_rdata = 64'h8000_0000_0000_0001;
        step();
        b_req_valid = 0;
        chk("ld_addr", {b_mem_req_valid, b_mem_req_addr}, {1'b1, 32'h8000_0008});
        step();
        step();
        chk("ld_rsp", {b_rsp_valid, b_rsp_err}, 2'b10);
        chk("ld_rdata", b_rsp_rdata, 64'h8000_0000_0000_0001);
        b_drain();

        // RV64 lw @0x80000004, upper word sign-extended
        b_req_valid = 1; b_req_funct3 = 3'b010; b_req_addr = 32'h8000_0004;
        b_mem_rsp_rdata = 64'h8765_4321_0000_0000;
        step();
        b_req_valid = 0;
        step();
        step();
        chk("lw64_rdata", b_rsp_rdata, 64'hFFFF_FFFF_8765_4321);
        b_drain();

        // RV64 sb @0x80000007 into the top lane
        b_req_valid = 1; b_req_wen = 1; b_req_funct3 = 3'b000;
        b_req_addr = 32'h8000_0007; b_req_wdata = 64'h0000_0000_0000_00AB;
        step();
        b_req_valid = 0;
        chk("sb64_mask", b_mem_req_wmask, 8'h80);
        chk("sb64_wdata", b_mem_req_wdata, 64'hAB00_0000_0000_0000);
        step();
        step();
        b_drain();

        // RV64 ld then async reset while in WAIT
        b_req_valid = 1; b_req_wen = 0; b_req_funct3 = 3'b011;
        b_req_addr = 32'h8000_0010; b_mem_rsp_valid = 0;
        step();
        b_req_valid = 0;
        step();
        chk("rstw_wait", {b_req_ready, b_rsp_valid, b_mem_req_valid}, 3'b000);
        #2 rst = 1'b1;
        #1;
        chk("rstw_req_ready", b_req_ready, 1);
        chk("rstw_ctrl", {b_rsp_valid, b_rsp_err, b_mem_req_valid, b_mem_req_wen}, 4'b0000);
        chk("rstw_data", {b_rsp_rdata, b_mem_req_wdata, b_mem_req_addr, b_mem_req_wmask}, 168'd0);
        step();
        rst = 1'b0;
        b_mem_rsp_valid = 1;
        step();
        step();
        b_mem_rsp_valid = 0;
        chk("rstw_late_rsp", {b_req_ready, b_rsp_valid, b_mem_req_valid}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
